tick_timer_arbiter: RTL
=======================

# tick_timer_arbiter

Shares one programmable tick timebase between NREQ requesters in the rcswitch transmit path. Each requester asks for a burst of `cnt` ticks spaced `div` input clocks apart. The block grants the timebase round-robin to one requester at a time and emits single-cycle tick enables in place of a free-running divided clock. It signals completion to the owner, then returns the timebase to the pool.

## Interface
- `NREQ`, default 2: number of requesters, range 1..8.
- `DIVW`, default 32: width of each tick-period field.
- `CNTW`, default 16: width of each tick-count field.
- `clk_i` input, 1: system clock; all logic on its rising edge.
- `rst_i` input, 1: reset; synchronous, active-high.
- `req_i` input, NREQ: per-requester request level.
- `div_i` input, NREQ*DIVW: tick period in clocks; requester k uses slice [k*DIVW +: DIVW].
- `cnt_i` input, NREQ*CNTW: number of ticks; requester k uses slice [k*CNTW +: CNTW].
- `gnt_o` output, NREQ: one-hot grant; at most one bit set.
- `tick_o` output, 1: one-cycle tick enable for the current owner.
- `done_o` output, NREQ: one-cycle completion pulse to the owner.
- `busy_o` output, 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE → RUN when any `req_i` is set.
  - RUN → WAIT_REL on the final tick, or when `cnt` = 0.
  - RUN → IDLE when the owner drops `req_i` (abort).
  - WAIT_REL → IDLE when the owner's `req_i` is low.
- Arbitration (IDLE): pick the first set `req_i` bit searching upward from `last+1` mod NREQ, where `last` is the previous owner. Update `last` to the new owner.
- On grant:
  - Latch the owner's `div` and `cnt` slices. Later input changes are ignored until the next grant.
  - Clear the prescaler; load the remaining-tick counter with `cnt`.
- `div` = 0 is treated as 1, giving a tick every clock.
- RUN:
  - The prescaler counts 0..div−1.
  - At div−1: assert `tick_o`, reload the prescaler to 0, decrement the remaining count.
- Final tick (remaining = 1): `tick_o` and `done_o[owner]` fire in the same cycle, then go to WAIT_REL.
- `cnt` = 0: no ticks. `done_o` pulses on the first RUN cycle, then WAIT_REL.
- Abort: if the owner's `req_i` falls in RUN, go to IDLE on the next edge with no `done_o` and no further `tick_o`.
- Requests from non-owners are held pending and never preempt the current owner.
- Counters wrap nowhere; widths are sized by the parameters. The prescaler comparison uses DIVW-bit unsigned arithmetic.

## Timing
- Reset values:
  - `gnt_o` = 0, `tick_o` = 0, `done_o` = 0, `busy_o` = 0.
  - State IDLE, `last` = NREQ−1, so requester 0 wins first.
- All outputs are registered.
- Grant latency: `req_i` sampled high at edge T gives `gnt_o` and `busy_o` high after edge T (one cycle).
- First tick comes `div` cycles after `gnt_o` rises; later ticks follow every `div` cycles.
- `gnt_o` stays high through the `done_o` cycle and in WAIT_REL. It drops the cycle after `req_i` is seen low.
- Minimum gap between two grants is 1 IDLE cycle.
- `rst_i` asserted mid-burst: all outputs are 0 after that edge, with no `done_o`.

## Structure
- Package `tick_timer_pkg`:
  - state enum {IDLE, RUN, WAIT_REL}.
  - Default DIVW/CNTW constants.
- Sub-module `rr_arbiter`: combinational round-robin pick from the `req` vector and the `last` pointer. It outputs a one-hot vector plus a valid flag.
- `tick_timer_arbiter` contains:
  - the FSM,
  - the latch registers,
  - the prescaler and remaining-tick counter.

## Test plan
- Reset: after 3 cycles of `rst_i`=1, all outputs are 0. Then `req_i`=01, div=4, cnt=3: `gnt_o`=01 one cycle later, ticks at +4/+8/+12 cycles, `done_o`=01 with the third tick.
- Contention: `req_i`=11 held, both cnt=1, div=2. Requester 0 is served first, then requester 1 after req0 drops. With req0 reasserted, 0 wins next, confirming round-robin.
- Edge values:
  - div=0, cnt=5: 5 consecutive ticks on consecutive cycles.
  - cnt=0: no tick, `done_o` pulses one cycle after grant.
- Abort: requester 1 drops `req_i` after 2 of 10 ticks. No `done_o`, `tick_o` stays 0, and pending requester 0 is granted 2 cycles later.
- Stability: change `div_i`/`cnt_i` during RUN. Tick spacing and count keep the latched values.
- Reset mid-burst: assert `rst_i` between ticks. Outputs are 0 next cycle, and a fresh request is granted to requester 0.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg
//   Shared types and constants for the tick timer arbiter.
//   - state_e    : arbiter/timer FSM states
//   - DEF_DIVW   : default width of a tick-period field
//   - DEF_CNTW   : default width of a tick-count field
//   - idx_width(): width of an index into NREQ requesters (minimum 1)
package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  localparam int DEF_DIVW = 32;
  localparam int DEF_CNTW = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_timer_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. Searches req_i upward starting one
//   position past last_i (wrapping modulo NREQ) and returns the first set
//   bit as a one-hot grant.
//   Ports:
//     req_i  [NREQ]  request vector
//     last_i [IDXW]  index of the previous owner
//     gnt_o  [NREQ]  one-hot pick (all zero when nothing requested)
//     vld_o          a pick was made
module rr_arbiter
  import tick_timer_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            vld_o
);

  logic [IDXW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    // i runs 1..NREQ so the previous owner is considered last.
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDXW'((int'(last_i) + i) % NREQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter
//   Shares one programmable tick timebase between NREQ requesters. The
//   owner is chosen round-robin; it receives cnt single-cycle tick enables
//   spaced div clocks apart, a done pulse with the last tick, and keeps the
//   grant until it releases its request.
//   Ports:
//     clk_i             system clock (rising edge)
//     rst_i             synchronous active-high reset
//     req_i  [NREQ]     request levels
//     div_i  [NREQ*DIVW] tick periods, slice k for requester k (0 acts as 1)
//     cnt_i  [NREQ*CNTW] tick counts, slice k for requester k
//     gnt_o  [NREQ]     one-hot grant
//     tick_o            tick enable for the owner
//     done_o [NREQ]     completion pulse to the owner
//     busy_o            FSM not idle
module tick_timer_arbiter
  import tick_timer_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int DIVW = DEF_DIVW,
  parameter  int CNTW = DEF_CNTW,
  localparam int IDXW = idx_width(NREQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*DIVW-1:0] div_i,
  input  logic [NREQ*CNTW-1:0] cnt_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             tick_o,
  output logic [NREQ-1:0]  done_o,
  output logic             busy_o
);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            tick_q, tick_d;
  logic            busy_q, busy_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [DIVW-1:0] div_m1_q, div_m1_d;
  logic [DIVW-1:0] presc_q, presc_d;
  logic [CNTW-1:0] rem_q, rem_d;

  logic [NREQ-1:0] arb_gnt;
  logic            arb_vld;
  logic [IDXW-1:0] arb_idx;
  logic [DIVW-1:0] div_sel;
  logic [CNTW-1:0] cnt_sel;
  logic            owner_req;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i  (req_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .vld_o  (arb_vld)
  );

  // Index and parameter slices of the arbiter's pick.
  always_comb begin
    arb_idx = '0;
    div_sel = '0;
    cnt_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_gnt[k]) begin
        arb_idx = IDXW'(k);
        div_sel = div_i[k*DIVW +: DIVW];
        cnt_sel = cnt_i[k*CNTW +: CNTW];
      end
    end
  end

  assign owner_req = |(req_i & gnt_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    tick_d   = 1'b0;
    done_d   = '0;
    last_d   = last_q;
    div_m1_d = div_m1_q;
    presc_d  = presc_q;
    rem_d    = rem_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d  = RUN;
          gnt_d    = arb_gnt;
          last_d   = arb_idx;
          // Period stored as div-1 so div=0 and div=1 both tick every clock.
          div_m1_d = (div_sel == '0) ? '0 : div_sel - DIVW'(1);
          presc_d  = '0;
          rem_d    = cnt_sel;
        end
      end
      RUN: begin
        if (!owner_req) begin
          // Abort wins over any tick or completion due this cycle.
          state_d = IDLE;
          gnt_d   = '0;
        end else if (rem_q == '0) begin
          done_d  = gnt_q;
          state_d = WAIT_REL;
        end else if (presc_q == div_m1_q) begin
          tick_d  = 1'b1;
          presc_d = '0;
          rem_d   = rem_q - CNTW'(1);
          if (rem_q == CNTW'(1)) begin
            done_d  = gnt_q;
            state_d = WAIT_REL;
          end
        end else begin
          presc_d = presc_q + DIVW'(1);
        end
      end
      WAIT_REL: begin
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= IDXW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  // Timebase registers are always reloaded on grant, so they carry no reset.
  always_ff @(posedge clk_i) begin
    div_m1_q <= div_m1_d;
    presc_q  <= presc_d;
    rem_q    <= rem_d;
  end

  assign gnt_o  = gnt_q;
  assign tick_o = tick_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule
